// File: rtl/topk_pkg.sv
// rtl/topk_pkg.sv - shared lane-count helpers and pad default for the top-k datapath
package topk_pkg;

  localparam int unsigned PAD_DEFAULT = 0;

  function automatic int lane_count(input int log_n);
    return 1 << log_n;
  endfunction

  // o_count must hold N itself, not just N-1
  function automatic int count_width(input int log_n);
    return log_n + 1;
  endfunction

endpackage

// File: rtl/vector_lane_insert.sv
// rtl/vector_lane_insert.sv - writes one element into a lane, optionally padding lanes above it
module vector_lane_insert
  import topk_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LANES      = 32,
  parameter int                    LANE_W     = 5,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
  input  logic [DATA_WIDTH*LANES-1:0] vec_in,
  input  logic [LANE_W-1:0]           lane,
  input  logic [DATA_WIDTH-1:0]       elem,
  input  logic                        pad_above,
  output logic [DATA_WIDTH*LANES-1:0] vec_out
);

  always_comb begin
    vec_out = vec_in;
    for (int k = 0; k < LANES; k++) begin
      if (lane == LANE_W'(k)) begin
        vec_out[k*DATA_WIDTH +: DATA_WIDTH] = elem;
      end else if (pad_above && (LANE_W'(k) > lane)) begin
        vec_out[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

endmodule

// File: rtl/vector_packer.sv
// rtl/vector_packer.sv - packs a scalar element stream into padded N-lane vectors
module vector_packer
  import topk_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    LOG_INPUT_NUM = 5,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = DATA_WIDTH'(PAD_DEFAULT)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              i_valid,
  input  logic [DATA_WIDTH-1:0]                             i_data,
  input  logic                                              i_last,
  output logic                                              i_ready,
  output logic                                              o_valid,
  output logic [DATA_WIDTH*lane_count(LOG_INPUT_NUM)-1:0]   o_data,
  output logic [count_width(LOG_INPUT_NUM)-1:0]             o_count,
  output logic                                              o_last,
  input  logic                                              o_ready
);

  localparam int N  = lane_count(LOG_INPUT_NUM);
  localparam int CW = count_width(LOG_INPUT_NUM);
  localparam int VW = DATA_WIDTH * N;
  localparam logic [VW-1:0] PAD_VEC = {N{PAD_VALUE}};

  logic [VW-1:0]            acc_q, acc_d;
  logic [LOG_INPUT_NUM-1:0] cnt_q, cnt_d;
  logic                     a_full_q, a_full_d;
  logic [CW-1:0]            a_count_q, a_count_d;
  logic                     a_last_q, a_last_d;
  logic [VW-1:0]            o_data_q, o_data_d;
  logic                     o_valid_q, o_valid_d;
  logic [CW-1:0]            o_count_q, o_count_d;
  logic                     o_last_q, o_last_d;

  logic          b_free, beat, complete;
  logic [VW-1:0] ins_vec;
  logic [CW-1:0] next_count;

  assign b_free     = !o_valid_q || o_ready;
  assign beat       = i_valid && !a_full_q;
  assign complete   = beat && ((&cnt_q) || i_last);
  assign next_count = CW'(cnt_q) + CW'(1);

  // Padding above cnt only matters for a completing beat
  vector_lane_insert #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (N),
    .LANE_W     (LOG_INPUT_NUM),
    .PAD_VALUE  (PAD_VALUE)
  ) u_insert (
    .vec_in    (acc_q),
    .lane      (cnt_q),
    .elem      (i_data),
    .pad_above (complete),
    .vec_out   (ins_vec)
  );

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    a_full_d  = a_full_q;
    a_count_d = a_count_q;
    a_last_d  = a_last_q;
    o_data_d  = o_data_q;
    o_valid_d = o_valid_q;
    o_count_d = o_count_q;
    o_last_d  = o_last_q;

    if (a_full_q && b_free) begin
      o_data_d  = acc_q;
      o_count_d = a_count_q;
      o_last_d  = a_last_q;
      o_valid_d = 1'b1;
      a_full_d  = 1'b0;
      acc_d     = PAD_VEC;
    end else if (complete && b_free) begin
      o_data_d  = ins_vec;
      o_count_d = next_count;
      o_last_d  = i_last;
      o_valid_d = 1'b1;
      acc_d     = PAD_VEC;
      cnt_d     = '0;
    end else begin
      if (o_valid_q && o_ready) begin
        o_valid_d = 1'b0;
      end
      if (complete) begin
        acc_d     = ins_vec;
        a_full_d  = 1'b1;
        a_count_d = next_count;
        a_last_d  = i_last;
        cnt_d     = '0;
      end else if (beat) begin
        acc_d = ins_vec;
        cnt_d = cnt_q + LOG_INPUT_NUM'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= PAD_VEC;
      cnt_q     <= '0;
      a_full_q  <= 1'b0;
      a_count_q <= '0;
      a_last_q  <= 1'b0;
      o_data_q  <= PAD_VEC;
      o_valid_q <= 1'b0;
      o_count_q <= '0;
      o_last_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      a_full_q  <= a_full_d;
      a_count_q <= a_count_d;
      a_last_q  <= a_last_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_count_q <= o_count_d;
      o_last_q  <= o_last_d;
    end
  end

  assign i_ready = !a_full_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_count = o_count_q;
  assign o_last  = o_last_q;

endmodule

// File: tb/tb_vector_packer.sv
// tb/tb_vector_packer.sv - directed self-checking bench for vector_packer (N=4, 8-bit, pad 0xFF)
module tb_vector_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic        i_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic [2:0]  o_count;
  logic        o_last;
  logic        o_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vector_packer #(
    .DATA_WIDTH    (8),
    .LOG_INPUT_NUM (2),
    .PAD_VALUE     (8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_count (o_count),
    .o_last  (o_last),
    .o_ready (o_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_data = 8'h55; i_last = 1'b1; o_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got %b want 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd0) $display("FAIL reset_o_count got %0d want 0", o_count); else pass_cnt++;
    total_cnt++; if (o_last !== 1'b0) $display("FAIL reset_o_last got %b want 0", o_last); else pass_cnt++;
    total_cnt++; if (o_data !== 32'hFFFFFFFF) $display("FAIL reset_o_data got %h want ffffffff", o_data); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready got %b want 1", i_ready); else pass_cnt++;
  endtask

  task automatic test_full_vector();
    o_ready = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL full_early_valid got %b want 0", o_valid); else pass_cnt++;
    send(8'h04, 1'b0);
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL full_valid got %b want 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== 32'h04030201) $display("FAIL full_data got %h want 04030201", o_data); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd4) $display("FAIL full_count got %0d want 4", o_count); else pass_cnt++;
    total_cnt++; if (o_last !== 1'b0) $display("FAIL full_last got %b want 0", o_last); else pass_cnt++;
    tick();
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL full_pulse_end got %b want 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_partial();
    o_ready = 1'b1;
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL partial_valid got %b want 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== 32'hFFFF0605) $display("FAIL partial_data got %h want ffff0605", o_data); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd2) $display("FAIL partial_count got %0d want 2", o_count); else pass_cnt++;
    total_cnt++; if (o_last !== 1'b1) $display("FAIL partial_last got %b want 1", o_last); else pass_cnt++;
    send(8'h07, 1'b0);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL partial_after_valid got %b want 0", o_valid); else pass_cnt++;
    send(8'h08, 1'b1);
    total_cnt++; if (o_data !== 32'hFFFF0807) $display("FAIL partial_next_lane0 got %h want ffff0807", o_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    o_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== 32'h04030201) $display("FAIL bp_hold got %h want 04030201", o_data); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL bp_i_ready got %b want 0", i_ready); else pass_cnt++;
    send(8'h09, 1'b0);
    total_cnt++; if (o_data !== 32'h04030201) $display("FAIL bp_stable got %h want 04030201", o_data); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL bp_still_full got %b want 0", i_ready); else pass_cnt++;
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    total_cnt++; if (o_data !== 32'h08070605) $display("FAIL bp_move got %h want 08070605", o_data); else pass_cnt++;
    total_cnt++; if (o_valid !== 1'b1) $display("FAIL bp_move_valid got %b want 1", o_valid); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd4) $display("FAIL bp_move_count got %0d want 4", o_count); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL bp_release got %b want 1", i_ready); else pass_cnt++;
    o_ready = 1'b1;
    tick();
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [31:0] got[$];
    logic [31:0] exp_v;
    int          drops = 0;
    o_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      i_valid = 1'b1;
      i_data  = 8'h10 + 8'(i);
      i_last  = 1'b0;
      if (i_ready !== 1'b1) drops++;
      tick();
      if (o_valid === 1'b1) got.push_back(o_data);
    end
    i_valid = 1'b0;
    tick();
    if (o_valid === 1'b1) got.push_back(o_data);
    total_cnt++; if (drops !== 0) $display("FAIL stream_i_ready drops got %0d want 0", drops); else pass_cnt++;
    total_cnt++; if (got.size() !== 3) $display("FAIL stream_count got %0d want 3", got.size()); else pass_cnt++;
    for (int v = 0; v < 3; v++) begin
      exp_v = {8'h13 + 8'(4*v), 8'h12 + 8'(4*v), 8'h11 + 8'(4*v), 8'h10 + 8'(4*v)};
      total_cnt++;
      if (v >= got.size()) $display("FAIL stream_vec%0d got missing want %h", v, exp_v);
      else if (got[v] !== exp_v) $display("FAIL stream_vec%0d got %h want %h", v, got[v], exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int outs = 0;
    o_ready = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", o_valid); else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b0);
      if (o_valid === 1'b1) outs++;
    end
    total_cnt++; if (o_data !== 32'h04030201) $display("FAIL rstmid_data got %h want 04030201", o_data); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_valid === 1'b1) outs++;
    end
    total_cnt++; if (outs !== 1) $display("FAIL rstmid_outputs got %0d want 1", outs); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; o_ready = 1'b1;
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
